// File: rtl/slave_accum_if.sv
// Job/stream bundle between the sequencing controller and a slave_accum worker.
// The master modport belongs to the controller/stream source. The slave modport belongs to the worker.
interface slave_accum_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ACC_W  = 16
);
  logic              trigger;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              done;
  logic              busy;
  logic [ACC_W-1:0]  sum;
  logic              overflow;

  modport master (
    output trigger, len, in_data, in_valid,
    input  in_ready, done, busy, sum, overflow
  );

  modport slave (
    input  trigger, len, in_data, in_valid,
    output in_ready, done, busy, sum, overflow
  );
endinterface

// File: rtl/slave_accum.sv
// Triggered worker: it accepts len beats from a valid/ready stream and sums them into a wide accumulator.
// It then pulses done once and holds the result until the next job.
module slave_accum #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ACC_W  = 16
) (
  input logic          clk,
  input logic          rst_n,
  slave_accum_if.slave bus
);
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    REARM = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [LEN_W-1:0]  count, count_next;
  logic [ACC_W-1:0]  acc, acc_next;
  logic              ovf, ovf_next;
  logic              in_ready_q, done_q, busy_q;
  logic [DATA_W-1:0] data_c;
  logic [SUM_W-1:0]  add_c;
  logic              beat_c;

  // in_ready_q is high exactly while in RUN, so it qualifies beats directly
  assign data_c = bus.in_data;
  assign beat_c = in_ready_q && bus.in_valid;
  assign add_c  = {1'b0, acc} + SUM_W'(data_c);

  always_comb begin
    state_next = state;
    count_next = count;
    acc_next   = acc;
    ovf_next   = ovf;
    unique case (state)
      IDLE: begin
        if (bus.trigger) begin
          count_next = bus.len;
          acc_next   = '0;
          ovf_next   = 1'b0;
          state_next = (bus.len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (beat_c) begin
          acc_next   = add_c[ACC_W-1:0];
          count_next = count - LEN_W'(1);
          if (add_c[ACC_W]) ovf_next = 1'b1;
          if (count == LEN_W'(1)) state_next = DONE;
        end
        // Abort wins over completion; a beat in the abort cycle still counts
        if (!bus.trigger) state_next = IDLE;
      end
      DONE:  state_next = REARM;
      REARM: if (!bus.trigger) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are flops loaded with the decode of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      acc        <= acc_next;
      ovf        <= ovf_next;
      in_ready_q <= (state_next == RUN);
      done_q     <= (state_next == DONE);
      busy_q     <= (state_next == RUN) || (state_next == DONE);
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.sum      = acc;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_slave_accum.sv
// Bench for slave_accum: a 16-bit and an 8-bit accumulator instance share one stimulus stream.
// Expected results are queued at job start and checked when done pulses.
module tb_slave_accum;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned ACC8_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              trigger;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;

  slave_accum_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ACC_W(ACC_W))  bus16 ();
  slave_accum_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ACC_W(ACC8_W)) bus8 ();

  assign bus16.trigger  = trigger;
  assign bus16.len      = len;
  assign bus16.in_data  = in_data;
  assign bus16.in_valid = in_valid;
  assign bus8.trigger   = trigger;
  assign bus8.len       = len;
  assign bus8.in_data   = in_data;
  assign bus8.in_valid  = in_valid;

  slave_accum #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus16)
  );
  slave_accum #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ACC_W(ACC8_W)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );

  typedef struct {
    int         len;
    int         gap;
    logic [7:0] data [8];
    int         sum16;
    int         ovf16;
    int         sum8;
    int         ovf8;
  } job_t;

  typedef struct {
    int sum;
    int ovf;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   dn16     = 0;
  int   dn8      = 0;
  exp_t e16, e8;
  job_t jobs [6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every done pulse consumes one queued expectation
  always @(negedge clk) begin
    if (bus16.done === 1'b1) begin
      dn16++;
      if (q16.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done16_unexpected: got done=1 expected no pulse at %0t", $time);
      end else begin
        e16 = q16.pop_front();
        check("sum16", 32'(bus16.sum), e16.sum);
        check("ovf16", 32'(bus16.overflow), e16.ovf);
      end
    end
    if (bus8.done === 1'b1) begin
      dn8++;
      if (q8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done8_unexpected: got done=1 expected no pulse at %0t", $time);
      end else begin
        e8 = q8.pop_front();
        check("sum8", 32'(bus8.sum), e8.sum);
        check("ovf8", 32'(bus8.overflow), e8.ovf);
      end
    end
  end

  task automatic run_job(input job_t j);
    exp_t e;
    e.sum = j.sum16; e.ovf = j.ovf16; q16.push_back(e);
    e.sum = j.sum8;  e.ovf = j.ovf8;  q8.push_back(e);
    trigger  = 1'b1;
    len      = LEN_W'(j.len);
    in_valid = 1'b0;
    step();  // acceptance edge T
    check("ready_t1", 32'(bus16.in_ready), 32'(j.len != 0));
    check("busy_t1", 32'(bus16.busy), 1);
    for (int i = 0; i < j.len; i++) begin
      in_data  = j.data[i];
      in_valid = 1'b1;
      step();
      if (j.gap != 0 && i < j.len - 1) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
    check("done_cycle16", 32'(bus16.done), 1);
    check("done_cycle8", 32'(bus8.done), 1);
    check("ready_in_done", 32'(bus16.in_ready), 0);
    step();  // REARM with trigger still high
    check("done_once", 32'(bus16.done), 0);
    check("busy_rearm", 32'(bus16.busy), 0);
    check("sum_held", 32'(bus16.sum), j.sum16);
    trigger = 1'b0;
    step();
    check("ready_idle", 32'(bus16.in_ready), 0);
    check("done_idle", 32'(bus16.done), 0);
  endtask

  initial begin
    jobs[0] = '{len:4, gap:0, data:'{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0},
                sum16:10, ovf16:0, sum8:10, ovf8:0};
    jobs[1] = '{len:3, gap:1, data:'{8'hFF, 8'hFF, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                sum16:765, ovf16:0, sum8:'hFD, ovf8:1};
    jobs[2] = '{len:2, gap:0, data:'{8'hFF, 8'h02, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                sum16:257, ovf16:0, sum8:1, ovf8:1};
    jobs[3] = '{len:0, gap:0, data:'{8'hAA, 8'hAA, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                sum16:0, ovf16:0, sum8:0, ovf8:0};
    jobs[4] = '{len:5, gap:1, data:'{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'd0, 8'd0, 8'd0},
                sum16:640, ovf16:0, sum8:'h80, ovf8:1};
    jobs[5] = '{len:1, gap:0, data:'{8'h00, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                sum16:0, ovf16:0, sum8:0, ovf8:0};

    // Reset with random inputs
    trigger  = 1'($urandom_range(0, 1));
    len      = LEN_W'($urandom_range(0, 255));
    in_data  = DATA_W'($urandom_range(0, 255));
    in_valid = 1'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus16.in_ready), 0);
    check("rst_done", 32'(bus16.done), 0);
    check("rst_busy", 32'(bus16.busy), 0);
    check("rst_sum", 32'(bus16.sum), 0);
    check("rst_ovf", 32'(bus16.overflow), 0);
    check("rst_sum8", 32'(bus8.sum), 0);
    trigger  = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_ready", 32'(bus16.in_ready), 0);
      check("idle_done", 32'(bus16.done), 0);
    end

    foreach (jobs[k]) run_job(jobs[k]);

    // Abort: drop trigger on the second of five beats; that beat still lands
    trigger  = 1'b1;
    len      = LEN_W'(5);
    in_valid = 1'b0;
    step();
    in_data  = 8'd7;
    in_valid = 1'b1;
    step();
    in_data  = 8'd9;
    trigger  = 1'b0;
    step();
    in_valid = 1'b0;
    check("abort_busy", 32'(bus16.busy), 0);
    check("abort_ready", 32'(bus16.in_ready), 0);
    check("abort_sum16", 32'(bus16.sum), 16);
    check("abort_sum8", 32'(bus8.sum), 16);
    repeat (3) step();
    check("abort_sum_held", 32'(bus16.sum), 16);
    check("abort_no_done", 32'(bus16.done), 0);

    run_job(jobs[0]);

    // Mid-job reset after two 0xFF beats
    trigger  = 1'b1;
    len      = LEN_W'(5);
    step();
    in_data  = 8'hFF;
    in_valid = 1'b1;
    step();
    step();
    check("pre_rst_sum16", 32'(bus16.sum), 'h1FE);
    check("pre_rst_ovf8", 32'(bus8.overflow), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_sum16", 32'(bus16.sum), 0);
    check("midrst_sum8", 32'(bus8.sum), 0);
    check("midrst_ovf8", 32'(bus8.overflow), 0);
    check("midrst_busy", 32'(bus16.busy), 0);
    check("midrst_ready", 32'(bus16.in_ready), 0);
    check("midrst_done", 32'(bus16.done), 0);
    trigger  = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_done", 32'(bus16.done), 0);

    run_job(jobs[1]);

    repeat (3) step();
    check("done_count16", dn16, 8);
    check("done_count8", dn8, 8);
    check("queue16_drained", q16.size(), 0);
    check("queue8_drained", q8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
